// File: rtl/jk_cmd_pkg.sv
// Shared types and constants for the JK command debouncer.
package jk_cmd_pkg;

    // Debounced state of one input channel
    typedef enum logic {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } ch_state_t;

    // {j,k} command encodings for the downstream JK flip-flop
    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b01;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    // Channel indices into pressed / event vectors
    localparam int CH_SET    = 0;
    localparam int CH_CLEAR  = 1;
    localparam int CH_TOGGLE = 2;
    localparam int NUM_CH    = 3;

    // Same-cycle events resolve clear > set > toggle; losers are dropped
    function automatic logic [1:0] resolve_cmd(input logic [NUM_CH-1:0] evt);
        logic [1:0] cmd;
        cmd = CMD_HOLD;
        if (evt[CH_CLEAR])       cmd = CMD_CLEAR;
        else if (evt[CH_SET])    cmd = CMD_SET;
        else if (evt[CH_TOGGLE]) cmd = CMD_TOGGLE;
        return cmd;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchronizer, hold counter and press/release FSM.
// press_evt pulses for one cycle, registered on the same edge the FSM
// enters PRESSED; releases never produce an event.
module debounce_channel
    import jk_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_evt
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    ch_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   evt_q, evt_d;

    // Metastability chain; raw enters at bit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State, counter and event registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    // Counter tracks consecutive cycles at the opposite level; it tops out
    // at CNT_LAST, where the state flips and the count restarts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        evt_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign level     = (state_q == PRESSED);
    assign press_evt = evt_q;

endmodule

// File: rtl/jk_cmd_debouncer.sv
// Debounces set/clear/toggle buttons and issues one-cycle {j,k} commands.
module jk_cmd_debouncer
    import jk_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_clear,
    input  logic       btn_toggle,
    output logic       j,
    output logic       k,
    output logic [2:0] pressed
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] evt;

    assign raw = {btn_toggle, btn_clear, btn_set};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .raw       (raw[i]),
            .level     (pressed[i]),
            .press_evt (evt[i])
        );
    end

    // Command register; no event means HOLD, so each press yields one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) {j, k} <= CMD_HOLD;
        else       {j, k} <= resolve_cmd(evt);
    end

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// Scoreboard bench: stimulus queues expected {j,k} commands with their
// cycle; negedge monitors pop and compare whenever a command appears.
module tb_jk_cmd_debouncer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_set = 1'b0, btn_clear = 1'b0, btn_toggle = 1'b0;
    logic       j, k;
    logic [2:0] pressed;
    logic       set2 = 1'b0, clear2 = 1'b0, toggle2 = 1'b0;
    logic       j2, k2;
    logic [2:0] pressed2;

    jk_cmd_debouncer #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .btn_set(btn_set), .btn_clear(btn_clear),
        .btn_toggle(btn_toggle), .j(j), .k(k), .pressed(pressed));

    jk_cmd_debouncer dut_def (
        .clk(clk), .reset(reset), .btn_set(set2), .btn_clear(clear2),
        .btn_toggle(toggle2), .j(j2), .k(k2), .pressed(pressed2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] jk; int cyc; } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for the DEBOUNCE_CYCLES=4 instance
    always @(negedge clk) begin : mon_a
        exp_t e;
        while (qa.size() > 0 && qa[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL cmd_missing_a: actual=none required jk=%b at cycle %0d", qa[0].jk, qa[0].cyc);
            void'(qa.pop_front());
        end
        if ({j, k} != 2'b00) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL cmd_spurious_a: actual jk=%b at cycle %0d required none", {j, k}, cyc);
            end else begin
                e = qa.pop_front();
                if (e.jk != {j, k} || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL cmd_a: actual jk=%b cycle %0d required jk=%b cycle %0d", {j, k}, cyc, e.jk, e.cyc);
                end
            end
        end
    end

    // Monitor for the default-parameter instance
    always @(negedge clk) begin : mon_b
        exp_t e;
        while (qb.size() > 0 && qb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL cmd_missing_b: actual=none required jk=%b at cycle %0d", qb[0].jk, qb[0].cyc);
            void'(qb.pop_front());
        end
        if ({j2, k2} != 2'b00) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL cmd_spurious_b: actual jk=%b at cycle %0d required none", {j2, k2}, cyc);
            end else begin
                e = qb.pop_front();
                if (e.jk != {j2, k2} || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL cmd_b: actual jk=%b cycle %0d required jk=%b cycle %0d", {j2, k2}, cyc, e.jk, e.cyc);
                end
            end
        end
    end

    // {toggle,clear,set} pattern, resulting command, resulting pressed
    typedef struct { logic [2:0] btn; logic [1:0] jk; logic [2:0] prs; } vec_t;
    vec_t vecs[6] = '{
        '{3'b100, 2'b11, 3'b100},
        '{3'b011, 2'b01, 3'b011},
        '{3'b001, 2'b10, 3'b001},
        '{3'b110, 2'b01, 3'b110},
        '{3'b101, 2'b10, 3'b101},
        '{3'b111, 2'b01, 3'b111}
    };

    initial begin
        int c0;
        int r;
        step(2);
        chk("reset_jk", {j, k}, 2'b00);
        chk("reset_pressed", pressed, 3'b000);
        chk("reset_pressed_def", pressed2, 3'b000);
        reset = 1'b0;
        step(3);

        // Single and simultaneous presses, priority resolution
        foreach (vecs[v]) begin
            c0 = cyc;
            {btn_toggle, btn_clear, btn_set} = vecs[v].btn;
            qa.push_back('{vecs[v].jk, c0 + 7});
            step(5);
            chk($sformatf("vec%0d_pressed_c5", v), pressed, 3'b000);
            step(1);
            chk($sformatf("vec%0d_pressed_c6", v), pressed, vecs[v].prs);
            step(6);
            {btn_toggle, btn_clear, btn_set} = 3'b000;
            step(10);
            chk($sformatf("vec%0d_released", v), pressed, 3'b000);
        end

        // Pulse shorter than the debounce window
        btn_set = 1'b1;
        step(3);
        btn_set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(2);
            chk("short_pulse_pressed", pressed, 3'b000);
        end

        // Bouncing press, then bouncing release
        c0 = cyc;
        btn_clear = 1'b1; step(1);
        btn_clear = 1'b0; step(1);
        btn_clear = 1'b1;
        qa.push_back('{2'b01, c0 + 9});
        step(12);
        chk("bounce_pressed", pressed, 3'b010);
        for (int i = 0; i < 2; i++) begin
            btn_clear = 1'b0; step(2);
            btn_clear = 1'b1; step(2);
        end
        chk("bounce_release_held", pressed, 3'b010);
        btn_clear = 1'b0;
        step(5);
        chk("release_c5", pressed, 3'b010);
        step(1);
        chk("release_c6", pressed, 3'b000);
        step(4);

        // Reset in the middle of a debounce, input held across release
        btn_set = 1'b1;
        step(3);
        reset = 1'b1;
        #1;
        chk("rst_debounce_jk", {j, k}, 2'b00);
        chk("rst_debounce_pressed", pressed, 3'b000);
        step(2);
        reset = 1'b0;
        r = cyc;
        qa.push_back('{2'b10, r + 7});
        step(10);
        chk("rst_debounce_repress", pressed, 3'b001);
        btn_set = 1'b0;
        step(10);

        // Reset while a command is on j/k; held input re-presses
        btn_toggle = 1'b1;
        step(6);
        chk("rst_cmd_pressed_pre", pressed, 3'b100);
        step(1);
        reset = 1'b1;
        #1;
        chk("rst_cmd_jk_async", {j, k}, 2'b00);
        chk("rst_cmd_pressed_async", pressed, 3'b000);
        step(2);
        reset = 1'b0;
        r = cyc;
        qa.push_back('{2'b11, r + 7});
        step(10);
        chk("rst_cmd_repress", pressed, 3'b100);
        btn_toggle = 1'b0;
        step(10);

        // Default parameters: 19-cycle latency
        c0 = cyc;
        toggle2 = 1'b1;
        qb.push_back('{2'b11, c0 + 19});
        step(17);
        chk("def_pressed_c17", pressed2, 3'b000);
        step(1);
        chk("def_pressed_c18", pressed2, 3'b100);
        step(6);
        toggle2 = 1'b0;
        step(25);
        chk("def_released", pressed2, 3'b000);

        step(3);
        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_cmd_debouncer.md
JK_CMD_DEBOUNCER -- requirements
Module: jk_cmd_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the consecutive synchronized cycles an input must hold to be accepted (legal range 2..65535).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the flip-flop depth of each input synchronizer (legal range 2..4).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port btn_set, input, 1 bit: raw asynchronous set request, active-high.
REQ-006 The block SHALL have port btn_clear, input, 1 bit: raw asynchronous clear request, active-high.
REQ-007 The block SHALL have port btn_toggle, input, 1 bit: raw asynchronous toggle request, active-high.
REQ-008 The block SHALL have port j, output, 1 bit: registered J command for a downstream JK flip-flop.
REQ-009 The block SHALL have port k, output, 1 bit: registered K command for a downstream JK flip-flop.
REQ-010 The block SHALL have port pressed, output, 3 bits: debounced levels {toggle, clear, set}, with set in bit 0.

Function
REQ-011 Each raw input SHALL pass through a SYNC_STAGES synchronizer, giving signal s.
REQ-012 Each channel SHALL run an FSM with two states, IDLE (released) and PRESSED, plus a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 In IDLE, the counter SHALL increment while s=1 and clear to 0 whenever s=0.
REQ-014 In IDLE, the cycle s=1 with counter=DEBOUNCE_CYCLES-1 SHALL move the channel to PRESSED, clear the counter and raise a one-cycle press event.
REQ-015 In PRESSED, the counter SHALL increment while s=0 and clear to 0 whenever s=1.
REQ-016 In PRESSED, s=0 with counter=DEBOUNCE_CYCLES-1 SHALL return the channel to IDLE with no event; release never generates a command.
REQ-017 pressed[n] SHALL be 1 exactly while channel n is in PRESSED.
REQ-018 The {j,k} outputs SHALL be registered one cycle after a press event: set gives 10, clear gives 01, toggle gives 11, and no event gives 00 (hold).
REQ-019 The {j,k} command SHALL last exactly one cycle per accepted press; holding an input never repeats the command.
REQ-020 Events in the same cycle SHALL resolve by priority clear > set > toggle; losing events are dropped, not queued, and their channels still enter PRESSED.
REQ-021 Latency SHALL be SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles from the first clk edge sampling a stable-high raw input to j/k asserted, which is 19 cycles at default parameters.
REQ-022 Any high pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no command and leave the channel in IDLE.
REQ-023 Counters SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-024 Asserting reset SHALL immediately clear all synchronizer flops, counters and j/k/pressed to 0, and force every FSM to IDLE, independent of clk.
REQ-025 Reset asserted mid-debounce or mid-command SHALL abort the operation, and no command SHALL be emitted on reset release.
REQ-026 An input held high across reset release SHALL be treated as a new press, issuing its command after the normal latency.

Structure
REQ-027 Package jk_cmd_pkg SHALL hold the channel state enum (IDLE, PRESSED), the 2-bit {j,k} command constants CMD_HOLD/CMD_SET/CMD_CLEAR/CMD_TOGGLE and the channel index constants.
REQ-028 One sub-module, debounce_channel, SHALL contain synchronizer, counter and FSM and be instantiated three times; the priority encoder and j/k registers SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless stated)
REQ-029 btn_toggle high from cycle 0 -> j=k=1 in cycle 7 only, pressed=3'b100 from cycle 6 onward.
REQ-030 btn_set high 3 cycles, then low -> j=k=0 throughout and pressed stays 3'b000.
REQ-031 btn_set and btn_clear rise in the same cycle and are held -> single {j,k}=01 in cycle 7 and pressed=3'b011.
REQ-032 btn_clear bouncing 1,0,1,1,1,1 then steady -> one {j,k}=01, 7 cycles after the final rising sample; releasing with 2-cycle bounces -> no further command and pressed[1] falls after 4 stable low cycles.
REQ-033 reset asserted 3 cycles into a btn_set debounce, input held -> outputs 0 asynchronously, then one {j,k}=10 7 cycles after reset release.
REQ-034 Default parameters with btn_toggle stable high -> j=k=1 exactly 19 cycles after the first sampling edge.
